muldiv_sched: RTL and testbench

Sequencing controller for the shared iterative multiply/divide unit in the execute stage. Accepts one M-extension operation at a time from the pipeline over a valid/ready handshake. Resolves the architecturally defined special cases itself and converts signed operands into an unsigned request for the unit. Applies sign fix-up and word-form extension to the unit's result, holds the result until the pipeline takes it, and drives the execute-stage stall.

---
 rtl/muldiv_sched.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - sequencing controller for the shared iterative multiply/divide unit
// Optional build macro: MULDIV_FASTPATH_EN adds zero-operand multiply and small-dividend divide bypasses.
module muldiv_sched #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            unit_start,
    output logic            unit_div,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    input  logic            unit_done,
    input  logic [XLEN-1:0] unit_lo,
    input  logic [XLEN-1:0] unit_hi,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic            is_div, is_divu, is_rem, is_remu, is_mul;
    logic            is_signed, is_divide;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_neg;
    logic            neg_a, neg_b;
    logic            div_zero, overflow, bypass;
    logic [XLEN-1:0] bypass_val;
    logic            accept;

    logic            q_word, q_div, q_rem, q_use_hi, q_neg_a, q_neg_b;
    logic            start_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] raw_res, fix_res;

    // Word-form results are always the low 32 bits sign-extended.
    function automatic logic [XLEN-1:0] word_fix(input logic word, input logic [XLEN-1:0] r);
        word_fix = word ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    // Decode the request, build effective-width operands and their magnitudes.
    always_comb begin
        is_div    = (req_op == 3'd1);
        is_divu   = (req_op == 3'd2);
        is_rem    = (req_op == 3'd3);
        is_remu   = (req_op == 3'd4);
        is_mul    = ~(is_div | is_divu | is_rem | is_remu);
        is_signed = is_div | is_rem;
        is_divide = ~is_mul;
        if (req_word) begin
            ext_a = is_signed ? {{(XLEN-32){req_a[31]}}, req_a[31:0]} : {{(XLEN-32){1'b0}}, req_a[31:0]};
            ext_b = is_signed ? {{(XLEN-32){req_b[31]}}, req_b[31:0]} : {{(XLEN-32){1'b0}}, req_b[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            ext_a   = req_a;
            ext_b   = req_b;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        neg_a = is_signed & ext_a[XLEN-1];
        neg_b = is_signed & ext_b[XLEN-1];
        mag_a = neg_a ? (~ext_a + 1'b1) : ext_a;
        mag_b = neg_b ? (~ext_b + 1'b1) : ext_b;
    end

    // Architecturally defined special cases are answered without the unit.
    always_comb begin
        div_zero   = is_divide & (ext_b == '0);
        overflow   = is_signed & (ext_a == min_neg) & (ext_b == {XLEN{1'b1}});
        bypass     = 1'b0;
        bypass_val = '0;
        if (div_zero) begin
            bypass     = 1'b1;
            bypass_val = (is_div | is_divu) ? {XLEN{1'b1}} : ext_a;
        end else if (overflow) begin
            bypass     = 1'b1;
            bypass_val = is_div ? ext_a : '0;
        end
`ifdef MULDIV_FASTPATH_EN
        else if (is_mul && (ext_a == '0 || ext_b == '0)) begin
            bypass     = 1'b1;
            bypass_val = '0;
        end else if (is_divide && (mag_a < mag_b)) begin
            bypass     = 1'b1;
            bypass_val = (is_div | is_divu) ? '0 : ext_a;
        end
`else
        else begin
            bypass     = 1'b0;
            bypass_val = '0;
        end
`endif
    end

    // Sign fix-up of the unit result: quotient sign from both operands, remainder from the dividend.
    always_comb begin
        raw_res = q_use_hi ? unit_hi : unit_lo;
        fix_res = ((q_div & (q_neg_a ^ q_neg_b)) | (q_rem & q_neg_a)) ? (~raw_res + 1'b1) : raw_res;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~flush;
                accept    = req_valid & ~flush;
                if (accept) state_next = bypass ? DONE : BUSY;
            end
            BUSY: begin
                if (unit_done)  state_next = flush ? IDLE : DONE;
                else if (flush) state_next = DRAIN;
            end
            DRAIN: begin
                if (unit_done) state_next = IDLE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        stall = req_valid & ~((state == DONE) & resp_ready) & ~flush;
    end

    // Operation context, unit request and held result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_word   <= 1'b0;
            q_div    <= 1'b0;
            q_rem    <= 1'b0;
            q_use_hi <= 1'b0;
            q_neg_a  <= 1'b0;
            q_neg_b  <= 1'b0;
            start_q  <= 1'b0;
            unit_div <= 1'b0;
            unit_a   <= '0;
            unit_b   <= '0;
            data_q   <= '0;
        end else begin
            start_q <= 1'b0;
            if (accept) begin
                q_word   <= req_word;
                q_div    <= is_div;
                q_rem    <= is_rem;
                q_use_hi <= is_rem | is_remu;
                q_neg_a  <= neg_a;
                q_neg_b  <= neg_b;
                if (bypass) begin
                    data_q <= word_fix(req_word, bypass_val);
                end else begin
                    unit_a   <= mag_a;
                    unit_b   <= mag_b;
                    unit_div <= is_divide;
                    start_q  <= 1'b1;
                end
            end
            if (state == BUSY && unit_done && !flush) data_q <= word_fix(q_word, fix_res);
        end
    end

    assign unit_start = start_q;
    assign resp_data  = data_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - self-checking bench for muldiv_sched with scoreboard and iterative unit model
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic        req_word;
    logic [63:0] req_a, req_b;
    logic        flush;
    logic        unit_start, unit_div, unit_done;
    logic [63:0] unit_a, unit_b, unit_lo, unit_hi;
    logic        resp_valid, resp_ready, stall;
    logic [63:0] resp_data;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    int          unit_lat = 3;
    int          pend     = 0;
    int          starts   = 0;
    logic [63:0] cap_a, cap_b;
    logic        cap_div;

    muldiv_sched #(.XLEN(64)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .unit_start(unit_start), .unit_div(unit_div), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_lo(unit_lo), .unit_hi(unit_hi),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .stall(stall)
    );

    always #5 clk = ~clk;

    // Iterative unit model: fixed latency, computes on the captured unsigned operands.
    initial begin
        unit_done = 1'b0;
        unit_lo   = '0;
        unit_hi   = '0;
        forever begin
            @(posedge clk);
            #1;
            unit_done = 1'b0;
            if (!resetn) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        unit_done = 1'b1;
                        if (cap_div) begin
                            unit_lo = (cap_b == 0) ? '1 : cap_a / cap_b;
                            unit_hi = (cap_b == 0) ? cap_a : cap_a % cap_b;
                        end else begin
                            unit_lo = cap_a * cap_b;
                            unit_hi = '0;
                        end
                    end
                end
                if (unit_start) begin
                    starts++;
                    cap_a   = unit_a;
                    cap_b   = unit_b;
                    cap_div = unit_div;
                    pend    = unit_lat;
                end
            end
        end
    end

    // Architectural reference for the M-extension results.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb, minv;
        logic [63:0] ua, ub, r;
        if (word) begin
            sa = {{32{a[31]}}, a[31:0]};
            sb = {{32{b[31]}}, b[31:0]};
            ua = {32'b0, a[31:0]};
            ub = {32'b0, b[31:0]};
            minv = 64'hFFFF_FFFF_8000_0000;
        end else begin
            sa = a; sb = b; ua = a; ub = b;
            minv = 64'h8000_0000_0000_0000;
        end
        case (op)
            3'd1: if (sb == 0) r = '1; else if (sa == minv && sb == -1) r = sa; else r = sa / sb;
            3'd2: r = (ub == 0) ? '1 : ua / ub;
            3'd3: if (sb == 0) r = sa; else if (sa == minv && sb == -1) r = '0; else r = sa % sb;
            3'd4: r = (ub == 0) ? ua : ua % ub;
            default: r = a * b;
        endcase
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    // Issue one operation, wait for its response, optionally hold it for some cycles, then consume.
    // exp_unit: 0 expect bypass, 1 expect unit path, 2 either.
    task automatic run_op(input string name, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input int exp_unit, input int hold);
        int st0, lat;
        logic got;
        exp_q.push_back(ref_result(op, word, a, b));
        st0 = starts;
        @(posedge clk); #1;
        req_op = op; req_word = word; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s accept: req_ready never seen, required 1", name);
        end
        @(posedge clk); #1;
        req_valid = (hold > 0);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; lat = i; break; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s resp_timeout: resp_valid never seen", name);
        end
        if (exp_unit == 0) begin
            checks++;
            if (lat !== 1 || starts !== st0) begin
                failures++;
                $display("FAIL %s bypass: latency=%0d starts=%0d, required latency=1 starts=0", name, lat, starts - st0);
            end
        end else if (exp_unit == 1) begin
            checks++;
            if (starts !== st0 + 1) begin
                failures++;
                $display("FAIL %s unit_start: starts=%0d, required 1", name, starts - st0);
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp_q[0] || stall !== 1'b1) begin
                failures++;
                $display("FAIL %s hold%0d: valid=%b data=%h stall=%b, required valid=1 data=%h stall=1",
                         name, i, resp_valid, resp_data, stall, exp_q[0]);
            end
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp_q[0] || stall !== 1'b0) begin
            failures++;
            $display("FAIL %s data: valid=%b data=%h stall=%b, required valid=1 data=%h stall=0",
                     name, resp_valid, resp_data, stall, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: resp_valid=%b req_ready=%b, required 0 and 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_word = 1'b0; req_a = '0; req_b = '0;
        flush = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || unit_start !== 1'b0 || unit_div !== 1'b0 || unit_a !== 64'd0 ||
            unit_b !== 64'd0 || resp_valid !== 1'b0 || resp_data !== 64'd0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: ready=%b start=%b div=%b a=%h b=%h valid=%b data=%h stall=%b, required 1 0 0 0 0 0 0 0",
                     req_ready, unit_start, unit_div, unit_a, unit_b, resp_valid, resp_data, stall);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_signed_div();
        run_op("div_m7_2", 3'd1, 1'b0, -64'sd7, 64'd2, 1, 0);
        checks++;
        if (cap_a !== 64'd7 || cap_b !== 64'd2 || cap_div !== 1'b1) begin
            failures++;
            $display("FAIL div_operands: a=%0d b=%0d div=%b, required 7 2 1", cap_a, cap_b, cap_div);
        end
        run_op("rem_m7_2", 3'd3, 1'b0, -64'sd7, 64'd2, 1, 0);
        run_op("div_7_m2", 3'd1, 1'b0, 64'd7, -64'sd2, 1, 0);
        run_op("remw_m9_4", 3'd3, 1'b1, 64'h0000_0000_FFFF_FFF7, 64'd4, 1, 0);
        run_op("mul_neg", 3'd0, 1'b0, -64'sd3, 64'd5, 1, 0);
        run_op("mulw", 3'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0001_0003, 1, 0);
        run_op("illegal_op7", 3'd7, 1'b0, 64'd11, 64'd13, 1, 0);
    endtask

    task automatic test_bypass();
        run_op("divu_zero", 3'd2, 1'b0, 64'h1234, 64'd0, 0, 0);
        run_op("remuw_zero", 3'd4, 1'b1, 64'h1_8000_0000, 64'd0, 0, 0);
        run_op("rem_zero", 3'd3, 1'b0, -64'sd5, 64'd0, 0, 0);
        run_op("divw_ovf", 3'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0);
        run_op("remw_ovf", 3'd3, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0);
        run_op("div_ovf64", 3'd1, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 0);
    endtask

    task automatic test_mul_zero();
`ifdef MULDIV_FASTPATH_EN
        run_op("mul_a0", 3'd0, 1'b0, 64'd0, 64'd5, 0, 0);
`else
        run_op("mul_a0", 3'd0, 1'b0, 64'd0, 64'd5, 1, 0);
`endif
    endtask

    task automatic test_hold();
        run_op("hold_divu", 3'd2, 1'b0, 64'd1000, 64'd7, 1, 5);
    endtask

    task automatic test_flush_drain();
        logic seen;
        unit_lat = 6;
        @(posedge clk); #1;
        req_op = 3'd2; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (unit_start !== 1'b1) begin
            failures++;
            $display("FAIL flush_start: unit_start=%b, required 1", unit_start);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL drain_cycle%0d: resp_valid=%b req_ready=%b, required 0 0", i, resp_valid, req_ready);
            end
            if (unit_done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL drain_done: unit_done never seen");
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_idle: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
        end
        unit_lat = 3;
    endtask

    task automatic test_reset_mid_op();
        logic bad;
        unit_lat = 10;
        @(posedge clk); #1;
        req_op = 3'd2; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || unit_start !== 1'b0 || unit_a !== 64'd0 || unit_b !== 64'd0 ||
            resp_valid !== 1'b0 || resp_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b start=%b a=%h b=%h valid=%b data=%h, required 1 0 0 0 0 0",
                     req_ready, unit_start, unit_a, unit_b, resp_valid, resp_data);
        end
        @(posedge clk); #3;
        resetn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_quiet: resp_valid rose after reset, required 0");
        end
        unit_lat = 3;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < 10; i++) begin
            a  = {$urandom, $urandom};
            b  = {32'd0, $urandom} | 64'd1;
            op = 3'($urandom_range(0, 4));
            run_op($sformatf("b2b%0d", i), op, 1'($urandom_range(0, 1)), a, b, 2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_signed_div();
        test_bypass();
        test_mul_zero();
        test_hold();
        test_flush_drain();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
